// File: rtl/mips_mc_controller.sv
// mips_mc_controller: multi-cycle MIPS control unit.
// Each instruction is sequenced through FETCH/DECODE/EXEC/MEM/WB. All control
// outputs are decoded combinationally from the state register, the IR fields,
// ALUzero and the memory acks, so a strobe is seen in the same cycle as the
// ack that completes a memory access.
//
// Memory handshake: im_req (FETCH) and DM_RE/DM_WE (MEM) are level requests
// held for as long as the FSM waits in that state. A cycle in which the
// matching ack is high completes the access: the write enables of that cycle
// take effect on the closing clock edge, and the FSM leaves the wait state.
//
// A watchdog bounds every memory wait to WAIT_MAX cycles (0 = never abort).
// Optional macro MC_PERF_CNT_EN adds the cyc_cnt/ret_cnt performance counters.
module mips_mc_controller #(
   parameter int WAIT_MAX = 15,
   parameter int CNT_W    = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [5:0]       opcode,
   input  logic [5:0]       funct,
   input  logic             ALUzero,
   input  logic             im_ack,
   input  logic             dm_ack,
   output logic             im_req,
   output logic             pc_we,
   output logic             ir_we,
   output logic             GRFWE,
   output logic             DM_WE,
   output logic             DM_RE,
   output logic [1:0]       WACtrl,
   output logic [1:0]       WDCtrl,
   output logic [1:0]       ALUCtrl,
   output logic             ALUBCtrl,
   output logic             EXTCtrl,
   output logic [1:0]       JumpCtrl,
   output logic [2:0]       state,
   output logic             instr_done,
   output logic             err
`ifdef MC_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0] cyc_cnt,
   output logic [CNT_W-1:0] ret_cnt
`endif
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] FN_ADDU  = 6'b100001;
   localparam logic [5:0] FN_SUBU  = 6'b100011;
   localparam logic [5:0] FN_JR    = 6'b001000;

   // Wait counter only needs to reach WAIT_MAX-1.
   localparam int              WC_W    = (WAIT_MAX > 2) ? $clog2(WAIT_MAX) : 1;
   localparam bit              WD_EN   = (WAIT_MAX > 0);
   localparam logic [WC_W-1:0] WD_LAST = WC_W'((WAIT_MAX > 0) ? WAIT_MAX - 1 : 0);

   state_t          r_state;
   logic [WC_W-1:0] r_wait_cnt;

   state_t     w_next;
   logic       w_im_req, w_pc_we, w_ir_we, w_grfwe, w_dm_we, w_dm_re;
   logic [1:0] w_wa, w_wd, w_alu, w_jump;
   logic       w_alub, w_ext, w_done, w_err;

   // Instruction decode from the IR fields.
   logic w_rtype, w_addu, w_subu, w_jr, w_ori, w_lw, w_sw, w_beq, w_lui, w_j, w_jal;
   logic w_to_exec, w_waiting, w_wd_hit;

   assign w_rtype   = (opcode == OP_RTYPE);
   assign w_addu    = w_rtype && (funct == FN_ADDU);
   assign w_subu    = w_rtype && (funct == FN_SUBU);
   assign w_jr      = w_rtype && (funct == FN_JR);
   assign w_ori     = (opcode == OP_ORI);
   assign w_lw      = (opcode == OP_LW);
   assign w_sw      = (opcode == OP_SW);
   assign w_beq     = (opcode == OP_BEQ);
   assign w_lui     = (opcode == OP_LUI);
   assign w_j       = (opcode == OP_J);
   assign w_jal     = (opcode == OP_JAL);
   assign w_to_exec = w_addu || w_subu || w_ori || w_lui || w_lw || w_sw || w_beq;

   // Watchdog fires when the last allowed wait cycle passes without an ack.
   assign w_waiting = ((r_state == S_FETCH) && !im_ack) || ((r_state == S_MEM) && !dm_ack);
   assign w_wd_hit  = WD_EN && (r_wait_cnt == WD_LAST);

   // Next-state and control decode for the current cycle.
   always_comb begin
      w_next   = r_state;
      w_im_req = 1'b0;
      w_pc_we  = 1'b0;
      w_ir_we  = 1'b0;
      w_grfwe  = 1'b0;
      w_dm_we  = 1'b0;
      w_dm_re  = 1'b0;
      w_wa     = 2'b00;
      w_wd     = 2'b00;
      w_alu    = 2'b00;
      w_alub   = 1'b0;
      w_ext    = 1'b0;
      w_jump   = 2'b00;
      w_done   = 1'b0;
      w_err    = 1'b0;

      // ALU operand selects stay stable from EXEC through MEM and WB.
      if ((r_state == S_EXEC) || (r_state == S_MEM) || (r_state == S_WB)) begin
         if (w_subu || w_beq) begin
            w_alu = 2'b01;
         end else if (w_ori) begin
            w_alu  = 2'b10;
            w_alub = 1'b1;
         end else if (w_lui) begin
            w_alu  = 2'b11;
            w_alub = 1'b1;
         end else if (w_lw || w_sw) begin
            w_alub = 1'b1;
            w_ext  = 1'b1;
         end
      end

      case (r_state)
         S_FETCH: begin
            w_im_req = 1'b1;
            if (im_ack) begin
               w_ir_we = 1'b1;
               w_pc_we = 1'b1;
               w_next  = S_DECODE;
            end else if (w_wd_hit) begin
               w_err  = 1'b1;
               w_next = S_FETCH;
            end
         end
         S_DECODE: begin
            if (w_j || w_jal) begin
               w_pc_we = 1'b1;
               w_jump  = 2'b10;
               w_done  = 1'b1;
               w_next  = S_FETCH;
               if (w_jal) begin
                  w_grfwe = 1'b1;
                  w_wa    = 2'b10;
                  w_wd    = 2'b10;
               end
            end else if (w_jr) begin
               w_pc_we = 1'b1;
               w_jump  = 2'b11;
               w_done  = 1'b1;
               w_next  = S_FETCH;
            end else if (w_to_exec) begin
               w_next = S_EXEC;
            end else begin
               // Unrecognised encoding retires as a NOP.
               w_done = 1'b1;
               w_next = S_FETCH;
            end
         end
         S_EXEC: begin
            if (w_beq) begin
               w_jump  = 2'b01;
               w_pc_we = ALUzero;
               w_done  = 1'b1;
               w_next  = S_FETCH;
            end else if (w_lw || w_sw) begin
               w_next = S_MEM;
            end else begin
               w_next = S_WB;
            end
         end
         S_MEM: begin
            w_dm_re = w_lw;
            w_dm_we = w_sw;
            if (!(w_lw || w_sw)) begin
               w_next = S_FETCH;
            end else if (dm_ack) begin
               if (w_lw) begin
                  w_next = S_WB;
               end else begin
                  w_done = 1'b1;
                  w_next = S_FETCH;
               end
            end else if (w_wd_hit) begin
               w_err  = 1'b1;
               w_next = S_FETCH;
            end
         end
         S_WB: begin
            w_grfwe = 1'b1;
            w_wa    = w_rtype ? 2'b01 : 2'b00;
            w_wd    = w_lw ? 2'b01 : 2'b00;
            w_done  = 1'b1;
            w_next  = S_FETCH;
         end
         default: begin
            w_next = S_FETCH;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_FETCH;
      end else begin
         r_state <= w_next;
      end
   end

   // Wait counter: counts ack-less cycles in FETCH/MEM, cleared on any move or abort.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wait_cnt <= '0;
      end else if ((w_next != r_state) || w_err) begin
         r_wait_cnt <= '0;
      end else if (w_waiting) begin
         r_wait_cnt <= r_wait_cnt + WC_W'(1);
      end
   end

   // Reset masks every output; state reads FETCH.
   assign im_req     = reset ? 1'b0  : w_im_req;
   assign pc_we      = reset ? 1'b0  : w_pc_we;
   assign ir_we      = reset ? 1'b0  : w_ir_we;
   assign GRFWE      = reset ? 1'b0  : w_grfwe;
   assign DM_WE      = reset ? 1'b0  : w_dm_we;
   assign DM_RE      = reset ? 1'b0  : w_dm_re;
   assign WACtrl     = reset ? 2'b00 : w_wa;
   assign WDCtrl     = reset ? 2'b00 : w_wd;
   assign ALUCtrl    = reset ? 2'b00 : w_alu;
   assign ALUBCtrl   = reset ? 1'b0  : w_alub;
   assign EXTCtrl    = reset ? 1'b0  : w_ext;
   assign JumpCtrl   = reset ? 2'b00 : w_jump;
   assign state      = reset ? 3'd0  : r_state;
   assign instr_done = reset ? 1'b0  : w_done;
   assign err        = reset ? 1'b0  : w_err;

`ifdef MC_PERF_CNT_EN
   logic [CNT_W-1:0] r_cyc_cnt;
   logic [CNT_W-1:0] r_ret_cnt;

   // Free-running cycle and retire counters, wrapping naturally.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_cyc_cnt <= '0;
         r_ret_cnt <= '0;
      end else begin
         r_cyc_cnt <= r_cyc_cnt + CNT_W'(1);
         if (w_done) begin
            r_ret_cnt <= r_ret_cnt + CNT_W'(1);
         end
      end
   end

   assign cyc_cnt = r_cyc_cnt;
   assign ret_cnt = r_ret_cnt;
`endif

endmodule

// File: tb/tb_mips_mc_controller.sv
// Bench for mips_mc_controller: the driver issues one instruction at a time
// with chosen ack delays; a reference model pushes the expected per-instruction
// signature; the monitor accumulates the observed signature and compares it
// whenever the DUT retires (instr_done) or aborts (err).
module tb_mips_mc_controller;
  localparam int WM    = 4;
  localparam int CNT_W = 32;

  localparam int K_ADDU   = 0;
  localparam int K_SUBU   = 1;
  localparam int K_JR     = 2;
  localparam int K_ORI    = 3;
  localparam int K_LW     = 4;
  localparam int K_SW     = 5;
  localparam int K_BEQ    = 6;
  localparam int K_LUI    = 7;
  localparam int K_J      = 8;
  localparam int K_JAL    = 9;
  localparam int K_NOP_OP = 10;
  localparam int K_NOP_FN = 11;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic reset;
  logic [5:0] opcode, funct;
  logic ALUzero, im_ack, dm_ack;
  logic im_req, pc_we, ir_we, GRFWE, DM_WE, DM_RE;
  logic [1:0] WACtrl, WDCtrl, ALUCtrl, JumpCtrl;
  logic ALUBCtrl, EXTCtrl, instr_done, err;
  logic [2:0] state;
`ifdef MC_PERF_CNT_EN
  logic [CNT_W-1:0] cyc_cnt, ret_cnt;
`endif

  always #5 clk = ~clk;

  mips_mc_controller #(.WAIT_MAX(WM), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .ALUzero(ALUzero),
    .im_ack(im_ack), .dm_ack(dm_ack), .im_req(im_req), .pc_we(pc_we), .ir_we(ir_we),
    .GRFWE(GRFWE), .DM_WE(DM_WE), .DM_RE(DM_RE), .WACtrl(WACtrl), .WDCtrl(WDCtrl),
    .ALUCtrl(ALUCtrl), .ALUBCtrl(ALUBCtrl), .EXTCtrl(EXTCtrl), .JumpCtrl(JumpCtrl),
    .state(state), .instr_done(instr_done), .err(err)
`ifdef MC_PERF_CNT_EN
    , .cyc_cnt(cyc_cnt), .ret_cnt(ret_cnt)
`endif
  );

  logic [17:0] strobes;
  assign strobes = {im_req, pc_we, ir_we, GRFWE, DM_WE, DM_RE, WACtrl, WDCtrl,
                    ALUCtrl, ALUBCtrl, EXTCtrl, JumpCtrl, instr_done, err};

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [7:0] cycles;
    logic [4:0] states;
    logic [1:0] n_pc;
    logic [1:0] n_ir;
    logic [1:0] jc_last;
    logic [1:0] jc_exec;
    logic [1:0] n_grf;
    logic [1:0] wa_sel;
    logic [1:0] wd_sel;
    logic [3:0] alu_exec;
    logic [3:0] alu_wb;
    logic [3:0] n_re;
    logic [3:0] n_we;
    logic       err;
    logic       done;
  } rec_t;
  localparam int REC_W = $bits(rec_t);

  logic [REC_W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  // {ALUCtrl, ALUBCtrl, EXTCtrl} each instruction class uses.
  function automatic logic [3:0] alu_of(input int kind);
    case (kind)
      K_SUBU, K_BEQ: return 4'b0100;
      K_ORI:         return 4'b1010;
      K_LUI:         return 4'b1110;
      K_LW, K_SW:    return 4'b0011;
      default:       return 4'b0000;
    endcase
  endfunction

  // Whole-instruction signature: wi/wd are ack-less wait cycles before the ack.
  function automatic rec_t model(input int kind, input int wi, input int wd, input bit z);
    rec_t r;
    int cyc;
    r = '0;
    if (wi >= WM) begin
      r.cycles = 8'(WM);
      r.states = 5'b00001;
      r.err    = 1'b1;
      return r;
    end
    cyc = wi + 2;                 // fetch + decode
    r.states = 5'b00011;
    r.n_pc = 2'd1;
    r.n_ir = 2'd1;
    if (kind == K_J || kind == K_JAL || kind == K_JR) begin
      r.n_pc    = 2'd2;
      r.jc_last = (kind == K_JR) ? 2'b11 : 2'b10;
      if (kind == K_JAL) begin
        r.n_grf  = 2'd1;
        r.wa_sel = 2'b10;
        r.wd_sel = 2'b10;
      end
      r.cycles = 8'(cyc);
      r.done   = 1'b1;
      return r;
    end
    if (kind == K_NOP_OP || kind == K_NOP_FN) begin
      r.cycles = 8'(cyc);
      r.done   = 1'b1;
      return r;
    end
    cyc = cyc + 1;                // exec
    r.states[2] = 1'b1;
    r.alu_exec  = alu_of(kind);
    if (kind == K_BEQ) begin
      r.jc_exec = 2'b01;
      if (z) begin
        r.n_pc    = 2'd2;
        r.jc_last = 2'b01;
      end
      r.cycles = 8'(cyc);
      r.done   = 1'b1;
      return r;
    end
    if (kind == K_LW || kind == K_SW) begin
      r.states[3] = 1'b1;
      if (wd >= WM) begin
        if (kind == K_LW) r.n_re = 4'(WM); else r.n_we = 4'(WM);
        r.cycles = 8'(cyc + WM);
        r.err    = 1'b1;
        return r;
      end
      cyc = cyc + wd + 1;
      if (kind == K_LW) r.n_re = 4'(wd + 1); else r.n_we = 4'(wd + 1);
      if (kind == K_SW) begin
        r.cycles = 8'(cyc);
        r.done   = 1'b1;
        return r;
      end
    end
    cyc = cyc + 1;                // write-back
    r.states[4] = 1'b1;
    r.n_grf  = 2'd1;
    r.wa_sel = (kind == K_ADDU || kind == K_SUBU) ? 2'b01 : 2'b00;
    r.wd_sel = (kind == K_LW) ? 2'b01 : 2'b00;
    r.alu_wb = alu_of(kind);
    r.cycles = 8'(cyc);
    r.done   = 1'b1;
    return r;
  endfunction

  function automatic bit known_op(input logic [5:0] op);
    return op inside {6'b000000, 6'b001101, 6'b100011, 6'b101011,
                      6'b000100, 6'b001111, 6'b000010, 6'b000011};
  endfunction

  task automatic finish_sim();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  endtask

  // ---------------- driver ----------------
  // Called at (or just after) a falling edge; returns at a falling edge.
  task automatic run_instr(input int kind, input int wi, input int wd, input bit z);
    int ci, cd, cyc;
    bit last;
    logic [5:0] op, fn;
    fn = 6'($urandom_range(0, 63));
    case (kind)
      K_ADDU: begin op = 6'b000000; fn = 6'b100001; end
      K_SUBU: begin op = 6'b000000; fn = 6'b100011; end
      K_JR:   begin op = 6'b000000; fn = 6'b001000; end
      K_ORI:  op = 6'b001101;
      K_LW:   op = 6'b100011;
      K_SW:   op = 6'b101011;
      K_BEQ:  op = 6'b000100;
      K_LUI:  op = 6'b001111;
      K_J:    op = 6'b000010;
      K_JAL:  op = 6'b000011;
      K_NOP_OP: begin
        op = 6'($urandom_range(0, 63));
        while (known_op(op)) op = 6'($urandom_range(0, 63));
      end
      default: begin
        op = 6'b000000;
        while (fn == 6'b100001 || fn == 6'b100011 || fn == 6'b001000)
          fn = 6'($urandom_range(0, 63));
      end
    endcase
    opcode  = op;
    funct   = fn;
    ALUzero = z;
    exp_q.push_back(model(kind, wi, wd, z));
    ci = 0; cd = 0; cyc = 0; last = 1'b0;
    while (!last) begin
      im_ack = im_req && (ci == wi);
      if (im_req) ci++;
      dm_ack = (DM_RE || DM_WE) && (cd == wd);
      if (DM_RE || DM_WE) cd++;
      #1;
      if (instr_done || err) last = 1'b1;
      cyc++;
      if (cyc > 100) begin
        checks++;
        errors++;
        $display("FAIL timeout: kind %0d no retire/abort after %0d cycles, required <= 100", kind, cyc);
        finish_sim();
      end
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    rec_t acc;
    logic [REC_W-1:0] e;
    int m_cyc, m_ret;
    acc = '0; m_cyc = 0; m_ret = 0;
    forever begin
      @(negedge clk);
      #4;
      if (reset) begin
        acc = '0; m_cyc = 0; m_ret = 0;
      end else begin
        acc.cycles = acc.cycles + 8'd1;
        if (state < 3'd5) acc.states[state] = 1'b1;
        if (pc_we) begin acc.n_pc = acc.n_pc + 2'd1; acc.jc_last = JumpCtrl; end
        if (ir_we) acc.n_ir = acc.n_ir + 2'd1;
        if (state == 3'd2) begin
          acc.jc_exec  = JumpCtrl;
          acc.alu_exec = {ALUCtrl, ALUBCtrl, EXTCtrl};
        end
        if (GRFWE) begin
          acc.n_grf  = acc.n_grf + 2'd1;
          acc.wa_sel = WACtrl;
          acc.wd_sel = WDCtrl;
          acc.alu_wb = {ALUCtrl, ALUBCtrl, EXTCtrl};
        end
        if (DM_RE) acc.n_re = acc.n_re + 4'd1;
        if (DM_WE) acc.n_we = acc.n_we + 4'd1;
        if (instr_done) acc.done = 1'b1;
        if (err) acc.err = 1'b1;
        if (instr_done || err) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL retire: got %h, required nothing (queue empty)", acc);
          end else begin
            e = exp_q.pop_front();
            if (e !== acc) begin
              errors++;
              $display("FAIL retire: got %h (cycles %0d), required %h (cycles %0d)",
                       acc, acc.cycles, e, e[REC_W-1 -: 8]);
            end
          end
`ifdef MC_PERF_CNT_EN
          checks++;
          if (cyc_cnt !== CNT_W'(m_cyc) || ret_cnt !== CNT_W'(m_ret)) begin
            errors++;
            $display("FAIL perf_cnt: got cyc %0d ret %0d, required cyc %0d ret %0d",
                     cyc_cnt, ret_cnt, m_cyc, m_ret);
          end
`endif
          if (instr_done) m_ret++;
          acc = '0;
        end
        m_cyc++;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int kind, wi, wd, n;
    reset = 1'b1; im_ack = 1'b1; dm_ack = 1'b1;
    opcode = 6'b100011; funct = 6'b0; ALUzero = 1'b0;

    // Reset held with acks high: everything quiet, state FETCH.
    repeat (2) begin
      @(negedge clk);
      #1;
      checks++;
      if (state !== 3'd0 || strobes !== 18'd0) begin
        errors++;
        $display("FAIL reset_quiet: got state %0d strobes %h, required 0 and 0", state, strobes);
      end
    end
    reset = 1'b0; im_ack = 1'b0; dm_ack = 1'b0;
    #1;
    checks++;
    if (im_req !== 1'b1 || state !== 3'd0) begin
      errors++;
      $display("FAIL first_fetch: got im_req %b state %0d, required 1 and 0", im_req, state);
    end

    // Directed cases from the plan.
    run_instr(K_ADDU, 0, 0, 1'b0);
    run_instr(K_LW,   0, 3, 1'b0);
    run_instr(K_BEQ,  0, 0, 1'b1);
    run_instr(K_BEQ,  0, 0, 1'b0);
    run_instr(K_JAL,  0, 0, 1'b0);
    run_instr(K_SW,   0, 99, 1'b0);
    run_instr(K_ORI,  3, 0, 1'b0);   // ack on the last allowed fetch cycle
    run_instr(K_LUI,  WM, 0, 1'b0);  // fetch abort

    // Randomized mix, mostly short waits with occasional long ones.
    for (int i = 0; i < 250; i++) begin
      kind = $urandom_range(0, 11);
      wi = ($urandom_range(0, 3) == 0) ? $urandom_range(2, 6) : $urandom_range(0, 1);
      wd = ($urandom_range(0, 3) == 0) ? $urandom_range(2, 6) : $urandom_range(0, 1);
      run_instr(kind, wi, wd, 1'($urandom_range(0, 1)));
    end

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d outstanding, required 0", exp_q.size());
    end

    // Reset arriving in the middle of a load's MEM wait.
    opcode = 6'b100011; funct = 6'b0; im_ack = 1'b1; dm_ack = 1'b0;
    n = 0;
    while (state != 3'd3 && n < 10) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    #1;
    checks++;
    if (state !== 3'd3 || DM_RE !== 1'b1) begin
      errors++;
      $display("FAIL mid_mem_setup: got state %0d DM_RE %b, required 3 and 1", state, DM_RE);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (state !== 3'd0 || strobes !== 18'd0) begin
      errors++;
      $display("FAIL mid_mem_reset: got state %0d strobes %h, required 0 and 0", state, strobes);
    end
    @(posedge clk);
    #1;
    reset = 1'b0; im_ack = 1'b0;
    #1;
    checks++;
    if (state !== 3'd0 || im_req !== 1'b1 || GRFWE !== 1'b0 || pc_we !== 1'b0) begin
      errors++;
      $display("FAIL after_reset: got state %0d im_req %b GRFWE %b pc_we %b, required 0 1 0 0",
               state, im_req, GRFWE, pc_we);
    end
`ifdef MC_PERF_CNT_EN
    checks++;
    if (cyc_cnt !== '0 || ret_cnt !== '0) begin
      errors++;
      $display("FAIL perf_reset: got cyc %0d ret %0d, required 0 0", cyc_cnt, ret_cnt);
    end
`endif
    finish_sim();
  end
endmodule
